io_handshake_unit: RTL and testbench
====================================

Name: io_handshake_unit

Overview:
- Responder side of the processor's IN/OUT instruction interface.
- While an IN instruction is active, the core is stalled until an operator enters a value on the switches and presses a debounced confirm button. The value is then handed back to the register-write path.
- OUT instructions latch a core register value into a persistent display register.
- Sits between the datapath/control unit and board I/O (switches, button, LEDs/display).

Parameters:
- DATA_W, 32, datapath word width; switch value zero-extended to this width.
- SW_W, 16, number of input switches.
- DEB_CYCLES, 50000, cycles Confirm must be stable before an edge is accepted (minimum 2).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InReq  in  1  high while an IN instruction (opcode 6'b011000) is in execute.
- OutReq  in  1  high while an OUT instruction (opcode 6'b011001) is in execute.
- OutData  in  DATA_W  register value to emit on OUT.
- Switches  in  SW_W  raw operator switches, treated as asynchronous.
- Confirm  in  1  raw push-button, active-high, treated as asynchronous.
- Stall  out  1  holds PC and pipeline while an IN is pending.
- InData  out  DATA_W  captured switch value, zero-extended.
- InValid  out  1  one-cycle strobe: InData is valid, register write may commit.
- Display  out  DATA_W  last OUT value.
- OutValid  out  1  one-cycle strobe on each accepted OUT.

Behaviour:
- Reset values: Stall=0, InValid=0, InData=0, Display=0, OutValid=0, FSM=IDLE, debounce counter=0, synchronizers=0.
- Synchronization:
  - Confirm passes through a 2-flop synchronizer.
  - Switches pass through a 2-flop synchronizer; sampled only at capture.
- Debounce:
  - The counter resets whenever the synchronized Confirm differs from the last stable level.
  - When the counter reaches DEB_CYCLES-1, the stable level updates.
  - A pressed event is the stable level going 0->1.
- FSM states:
  - IDLE: Stall = InReq (combinational, same cycle). InReq=1 -> WAIT_REL.
  - WAIT_REL: Stall=1. Waits for stable Confirm=0, so a press held from before the request is ignored; stable 0 -> WAIT_PRESS.
  - WAIT_PRESS: Stall=1. On a pressed event, capture the synchronized Switches into InData -> DONE.
  - DONE: Stall=0, InValid=1 for exactly one cycle -> COOLDOWN.
  - COOLDOWN: InValid=0, Stall=0, one cycle, so the core can advance past the IN and InReq can drop; -> IDLE. InReq still high in COOLDOWN is not a new request.
- Latency: press-to-InValid = 2 (sync) + DEB_CYCLES + 1 cycles minimum.
- InReq dropping while in WAIT_REL or WAIT_PRESS (flush): return to IDLE next cycle, no InValid, InData unchanged.
- OUT path:
  - An OutReq rising edge (registered previous OutReq) loads Display <= OutData and pulses OutValid for one cycle.
  - A held OutReq does not reload.
  - Independent of the IN FSM; OutReq and InReq both high is legal and both are serviced.
- Asynchronous reset mid-wait: Stall drops immediately (combinationally from reset), and the pending IN is discarded.
- Width rule: InData = {(DATA_W-SW_W) zeros, Switches}. If SW_W >= DATA_W, the low DATA_W bits are used.

Optional Feature:
- Macro IO_SEVEN_SEG_EN.
- When defined: adds output Seg[8*7-1:0] (active-low segments, 8 hex digits of Display) and output An[7:0] (digit enables). Digits are time-multiplexed by a free-running refresh counter; one digit is active per 2^14 cycles. Reset: An=8'hFF, Seg all ones.
- When undefined: these ports and the refresh logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package io_pkg:
  - FSM state enum {IDLE, WAIT_REL, WAIT_PRESS, DONE, COOLDOWN}.
  - OP_IN = 6'b011000 and OP_OUT = 6'b011001.
  - 4-bit hex -> 7-segment lookup constant.
- Sub-module io_debounce: synchronizer, counter and stable-level edge detector; outputs a one-cycle pressed event and the stable level.

Test Plan:
- Reset: hold rst_n=0 with InReq=1 -> Stall=0, Display=0, InValid=0. Release -> Stall=1 the same cycle.
- Basic IN (DEB_CYCLES=4): InReq=1, Switches=16'h00A5, press Confirm for 10 cycles -> InValid pulses once, InData=32'h000000A5, Stall falls the same cycle.
- Pre-held button: Confirm=1 before InReq rises -> no capture until Confirm released then pressed again; exactly one InValid.
- Bounce: Confirm toggling every cycle for 20 cycles, then steady 1 -> no InValid during toggling; exactly one InValid after stable.
- OUT: OutReq high 3 cycles with OutData=32'hDEADBEEF -> OutValid single pulse, Display=32'hDEADBEEF; subsequent OutData change while OutReq is held does not alter Display.
- Flush: InReq drops in WAIT_PRESS -> Stall=0 next cycle, no InValid, InData retains its prior value.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the IN/OUT handshake unit: FSM states, opcodes, 7-segment table.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REL,
        WAIT_PRESS,
        DONE,
        COOLDOWN
    } io_state_e;

    localparam logic [5:0] OP_IN  = 6'b011000;
    localparam logic [5:0] OP_OUT = 6'b011001;

    // Active-low segments {g,f,e,d,c,b,a}; digit 0 occupies the least significant 7 bits.
    localparam logic [16*7-1:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        return SEG_LUT[int'(h)*7 +: 7];
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Synchronizes and debounces the confirm button; emits a one-cycle pressed event and the stable level.
// Latency: 2 sync cycles + DEB_CYCLES of stable input before the level/edge update.
// Backpressure: none; free-running, the event is lost if nobody looks at it.
module io_debounce
#(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pressed_o,
    output logic level_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             pressed_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles the input disagrees with the stable level; any bounce back restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            pressed_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                cnt_q     <= '0;
                level_q   <= sync2_q;
                pressed_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pressed_o = pressed_q;
    assign level_o   = level_q;

endmodule

// File: rtl/io_handshake_unit.sv
// Responder for IN/OUT instructions: stalls the core on IN until a debounced confirm, latches OUT to Display.
// Latency: IN completes >= 2 + DEB_CYCLES + 1 cycles after the press; OutValid/Display one cycle after OutReq rises.
// Backpressure: Stall holds the core while an IN waits; OUT is always accepted. Optional 7-seg via IO_SEVEN_SEG_EN.
module io_handshake_unit
    import io_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 16,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InReq,
    input  logic              OutReq,
    input  logic [DATA_W-1:0] OutData,
    input  logic [SW_W-1:0]   Switches,
    input  logic              Confirm,
    output logic              Stall,
    output logic [DATA_W-1:0] InData,
    output logic              InValid,
    output logic [DATA_W-1:0] Display,
    output logic              OutValid
`ifdef IO_SEVEN_SEG_EN
    ,
    output logic [8*7-1:0]    Seg,
    output logic [7:0]        An
`endif
);

    io_state_e         state_q;
    logic [SW_W-1:0]   sw_sync1_q;
    logic [SW_W-1:0]   sw_sync2_q;
    logic [DATA_W-1:0] sw_ext;
    logic [DATA_W-1:0] in_data_q;
    logic              in_valid_q;
    logic [DATA_W-1:0] display_q;
    logic              out_valid_q;
    logic              out_req_prev_q;
    logic              pressed;
    logic              level;

    io_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (Confirm),
        .pressed_o (pressed),
        .level_o   (level)
    );

    // Switches are synchronized continuously but only looked at when a press is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= Switches;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    generate
        if (SW_W >= DATA_W) begin : g_sw_trunc
            assign sw_ext = sw_sync2_q[DATA_W-1:0];
        end else begin : g_sw_zext
            assign sw_ext = {{(DATA_W-SW_W){1'b0}}, sw_sync2_q};
        end
    endgenerate

    // IN handshake FSM: wait for release, then a fresh press, then strobe the captured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
        end else begin
            in_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (InReq) state_q <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!InReq)      state_q <= IDLE;
                    else if (!level) state_q <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (!InReq) begin
                        state_q <= IDLE;
                    end else if (pressed) begin
                        in_data_q  <= sw_ext;
                        in_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE:     state_q <= COOLDOWN;
                COOLDOWN: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Stall must react to InReq in the same cycle and drop the instant reset asserts.
    assign Stall = rst_n & (((state_q == IDLE) & InReq) |
                            (state_q == WAIT_REL) | (state_q == WAIT_PRESS));

    // OUT path: load Display on the rising edge of OutReq only, so a held request does not reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_req_prev_q <= 1'b0;
            display_q      <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            out_req_prev_q <= OutReq;
            out_valid_q    <= OutReq & ~out_req_prev_q;
            if (OutReq & ~out_req_prev_q) display_q <= OutData;
        end
    end

    assign InData   = in_data_q;
    assign InValid  = in_valid_q;
    assign Display  = display_q;
    assign OutValid = out_valid_q;

`ifdef IO_SEVEN_SEG_EN
    logic [16:0]    refresh_q;
    logic [8*7-1:0] seg_q;
    logic [7:0]     an_q;

    // Free-running refresh: each of the 8 digits is enabled for 2^14 cycles in turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            seg_q     <= '1;
            an_q      <= 8'hFF;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            an_q      <= ~(8'b1 << refresh_q[16:14]);
            for (int i = 0; i < 8; i++) begin
                seg_q[i*7 +: 7] <= (i*4 < DATA_W) ? hex2seg(display_q[(i*4) % DATA_W +: 4]) : 7'h7F;
            end
        end
    end

    assign Seg = seg_q;
    assign An  = an_q;
`endif

endmodule

// File: tb/tb_io_handshake_unit.sv
// Self-checking bench for io_handshake_unit with a short debounce window.
// Latency: press-to-InValid is a handful of cycles with DEB_CYCLES=4.
// Backpressure: Stall is checked while an IN is pending.
module tb_io_handshake_unit;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              InReq;
    logic              OutReq;
    logic [DATA_W-1:0] OutData;
    logic [SW_W-1:0]   Switches;
    logic              Confirm;
    logic              Stall;
    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic [DATA_W-1:0] Display;
    logic              OutValid;

    io_handshake_unit #(
        .DATA_W     (DATA_W),
        .SW_W       (SW_W),
        .DEB_CYCLES (DEB),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .InReq    (InReq),
        .OutReq   (OutReq),
        .OutData  (OutData),
        .Switches (Switches),
        .Confirm  (Confirm),
        .Stall    (Stall),
        .InData   (InData),
        .InValid  (InValid),
        .Display  (Display),
        .OutValid (OutValid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int in_pulses = 0;
    int out_pulses = 0;
    logic [DATA_W-1:0] in_q[$];
    logic [DATA_W-1:0] out_q[$];

    // mode: 0 = clean press, 1 = button held before request, 2 = bouncing before steady press
    typedef struct {
        logic [SW_W-1:0]   sw;
        logic [DATA_W-1:0] exp;
        int                mode;
    } in_vec_t;

    in_vec_t vecs[5];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe is matched against the value queued when the stimulus was driven.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (InValid) begin
                in_pulses++;
                if (in_q.size() == 0) begin
                    chk("unexpected_invalid", 32'd1, 32'd0);
                end else begin
                    chk("in_data", InData, in_q.pop_front());
                    chk("stall_at_invalid", {31'd0, Stall}, 32'd0);
                end
            end
            if (OutValid) begin
                out_pulses++;
                if (out_q.size() == 0) chk("unexpected_outvalid", 32'd1, 32'd0);
                else                   chk("display", Display, out_q.pop_front());
            end
        end
    end

    initial begin
        int base;
        vecs[0] = '{sw: 16'h00A5, exp: 32'h0000_00A5, mode: 0};
        vecs[1] = '{sw: 16'h1234, exp: 32'h0000_1234, mode: 1};
        vecs[2] = '{sw: 16'hFFFF, exp: 32'h0000_FFFF, mode: 2};
        vecs[3] = '{sw: 16'h8001, exp: 32'h0000_8001, mode: 0};
        vecs[4] = '{sw: 16'h0000, exp: 32'h0000_0000, mode: 0};

        rst_n = 1'b0; InReq = 1'b1; OutReq = 1'b0; OutData = '0; Switches = '0; Confirm = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_display", Display, 32'd0);
        chk("rst_invalid", {31'd0, InValid}, 32'd0);
        chk("rst_indata", InData, 32'd0);
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_stall", {31'd0, Stall}, 32'd1);
        InReq = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_stall", {31'd0, Stall}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            Switches = vecs[v].sw;
            if (vecs[v].mode == 1) begin
                Confirm = 1'b1;
                repeat (10) @(negedge clk);
            end
            base = in_pulses;
            InReq = 1'b1;
            in_q.push_back(vecs[v].exp);
            repeat (2) @(negedge clk);
            chk("stall_pending", {31'd0, Stall}, 32'd1);
            if (vecs[v].mode == 1) begin
                repeat (10) @(negedge clk);
                chk("preheld_no_capture", in_pulses - base, 0);
                Confirm = 1'b0;
                repeat (8) @(negedge clk);
            end
            if (vecs[v].mode == 2) begin
                for (int t = 0; t < 20; t++) begin
                    Confirm = ~Confirm;
                    @(negedge clk);
                end
                chk("bounce_no_capture", in_pulses - base, 0);
                chk("bounce_stall", {31'd0, Stall}, 32'd1);
            end
            Confirm = 1'b1;
            repeat (10) @(negedge clk);
            Confirm = 1'b0;
            repeat (8) @(negedge clk);
            InReq = 1'b0;
            repeat (8) @(negedge clk);
            chk("one_invalid", in_pulses - base, 1);
            chk("stall_after", {31'd0, Stall}, 32'd0);
        end

        // Flush: request withdrawn while waiting for the press.
        base = in_pulses;
        Switches = 16'h5555;
        InReq = 1'b1;
        repeat (4) @(negedge clk);
        chk("flush_stall_before", {31'd0, Stall}, 32'd1);
        InReq = 1'b0;
        @(negedge clk);
        chk("flush_stall_after", {31'd0, Stall}, 32'd0);
        Confirm = 1'b1;
        repeat (10) @(negedge clk);
        Confirm = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush_no_invalid", in_pulses - base, 0);
        chk("flush_indata_kept", InData, 32'h0000_0000);

        // OUT: single pulse on rising edge; data change while held is ignored.
        base = out_pulses;
        OutData = 32'hDEAD_BEEF;
        OutReq = 1'b1;
        out_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        OutData = 32'h1234_5678;
        repeat (2) @(negedge clk);
        OutReq = 1'b0;
        repeat (3) @(negedge clk);
        chk("out_one_pulse", out_pulses - base, 1);
        chk("display_held", Display, 32'hDEAD_BEEF);

        // OUT and IN concurrently.
        base = out_pulses;
        Switches = 16'h0C0D;
        InReq = 1'b1;
        OutData = 32'h0000_5A5A;
        OutReq = 1'b1;
        out_q.push_back(32'h0000_5A5A);
        in_q.push_back(32'h0000_0C0D);
        repeat (3) @(negedge clk);
        OutReq = 1'b0;
        Confirm = 1'b1;
        repeat (10) @(negedge clk);
        Confirm = 1'b0;
        InReq = 1'b0;
        repeat (8) @(negedge clk);
        chk("concurrent_out", out_pulses - base, 1);
        chk("concurrent_display", Display, 32'h0000_5A5A);

        chk("in_queue_drained", in_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
